// File: rtl/mux_4x1_rr_arbiter_if.sv
// Bundle between the four requesters and the round-robin mux arbiter.
// master = requester side, slave = arbiter side.
interface mux_4x1_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] din;
  logic [3:0]         gnt;
  logic [1:0]         sel;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic               busy;

  modport master (
    output req, din,
    input  gnt, sel, out, out_valid, busy
  );

  modport slave (
    input  req, din,
    output gnt, sel, out, out_valid, busy
  );
endinterface

// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter driving a 4:1 mux select, with a registered data output.
// Optional hold limit (forced rotation after MAX_HOLD cycles): `define ARB_HOLD_LIMIT_EN.
//
// state | meaning
// IDLE  | no grant, gnt = 0, sel holds its last value
// GRANT | exactly one gnt bit set, sel is its index
module mux_4x1_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input logic             clk,
  input logic             rst_n,
  mux_4x1_rr_arbiter_if.slave bus
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 1..255");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic [3:0]       cand;
  logic [1:0]       win;
  logic             force_rot;

  // First requesting index in the order start, start+1, start+2, start+3.
  function automatic logic [1:0] rr_pick(input logic [3:0] c, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (c[idx]) pick = idx;
    end
    return pick;
  endfunction

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_TC = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;

  assign force_rot = (state_q == GRANT) && (hold_q == HOLD_TC) && (|(bus.req & ~gnt_q));
`else
  assign force_rot = 1'b0;
`endif

  // In GRANT the current holder never competes with itself: it is either kept or released.
  assign cand = (state_q == GRANT) ? (bus.req & ~gnt_q) : bus.req;
  assign win  = rr_pick(cand, ptr_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef ARB_HOLD_LIMIT_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (|cand) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          ptr_d   = win + 2'd1;
`ifdef ARB_HOLD_LIMIT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
        if (bus.req[sel_q] && !force_rot) begin
`ifdef ARB_HOLD_LIMIT_EN
          if (hold_q != HOLD_TC) hold_d = hold_q + 1'b1;
`endif
        end else if (|cand) begin
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          ptr_d   = win + 2'd1;
`ifdef ARB_HOLD_LIMIT_EN
          hold_d  = '0;
`endif
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`endif

  // Datapath lags the grant by one edge; out keeps its last word while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (|gnt_q) out_q <= bus.din[int'(sel_q)*WIDTH +: WIDTH];
      out_valid_q <= |gnt_q;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = |gnt_q;

endmodule

// File: doc/mux_4x1_rr_arbiter.md
# mux_4x1_rr_arbiter

Round-robin arbiter that shares one 4-to-1 multiplexer channel among four requesters. It grants exactly one requester at a time and drives the mux select from the grant. It registers the selected data word onto a single output with a valid flag. It sits in front of the lab-7 multiplexer datapath and replaces the static, externally driven select.

## Interface
- WIDTH, 8, data width of each requester word and of Out
- MAX_HOLD, 4, maximum consecutive grant cycles under contention (legal range 1..255); used only when ARB_HOLD_LIMIT_EN is defined

- Clk  input  1  rising-edge clock, single clock domain
- Rst_n  input  1  asynchronous, active-low reset
- Req  input  4  request per requester; held high for as long as the requester wants the channel
- Din  input  4*WIDTH  packed data {D3,D2,D1,D0}; D0 = Din[WIDTH-1:0]
- Gnt  output  4  one-hot grant, registered; all-zero when idle
- Sel  output  2  mux select, binary index of the granted requester, registered
- Out  output  WIDTH  registered selected data word
- Out_valid  output  1  high when Out carries a word captured under a grant
- Busy  output  1  high while any grant is active (equals |Gnt)

## Operation
- State machine with two states:
  - IDLE: Gnt=0.
  - GRANT: exactly one Gnt bit is set.
- Round-robin pointer Ptr (2 bits).
  - Search order for a new grant is Ptr, Ptr+1, Ptr+2, Ptr+3, all modulo 4.
  - When index k is granted, Ptr <= (k+1) mod 4.
- IDLE -> GRANT: any Req bit is high at the edge. The winner is the first requesting index in search order. Gnt, Sel and Busy update at that edge.
- IDLE with Req=0: stay in IDLE. Sel holds its last value.
- GRANT, Req[Sel] still high, no forced rotation: keep the current grant. The hold counter increments, saturating at MAX_HOLD-1.
- GRANT, Req[Sel] low at the edge: release the current grant.
  - The other Req bits (current index masked) are arbitrated in the same edge.
  - If any are pending, grant the winner directly. There is no idle bubble.
  - Otherwise, go to IDLE with Gnt=0.
- New grants always reset the hold counter to 0.
- Same-edge events:
  - A release and new requests arriving together are handled in one arbitration.
  - A requester that drops Req and re-asserts it in the next cycle competes normally. Because Ptr has moved past it, it has the lowest priority.
- Datapath, every edge:
  - Out <= Din slice selected by the current Sel, and Out_valid <= |Gnt, both registered.
  - When Gnt=0, Out holds its last value and Out_valid=0.

## Timing
- Reset (asserted asynchronously, any time, including mid-grant): Gnt=0, Sel=0, Out=0, Out_valid=0, Busy=0, Ptr=0, hold counter=0, state IDLE. The block stays in reset while Rst_n is low.
- Req sampled at edge t gives Gnt/Sel/Busy valid after edge t.
- Out and Out_valid follow Gnt by one cycle.
- Release: Req[Sel] low at edge t clears or moves the grant after edge t. Out_valid for the old requester drops (or switches to the new requester's word) after edge t+1.
- Handoff between two requesters costs zero cycles of channel idle.
- Hold counter width is ceil(log2(MAX_HOLD))+1 bits.

## Configuration
- ARB_HOLD_LIMIT_EN defined:
  - In GRANT, when the hold counter == MAX_HOLD-1 and any other Req bit is high, the next edge forces rotation to the next requester in search order, even though Req[Sel] is still high.
  - If no other requester is pending, the grant continues and the counter stays saturated.
  - MAX_HOLD=1 rotates every cycle under contention.
- ARB_HOLD_LIMIT_EN undefined:
  - No hold counter is built and MAX_HOLD is ignored.
  - A grant lasts until the holder deasserts Req.

## Test plan
- Reset: drive Rst_n=0 mid-grant with Gnt=0100 -> immediately Gnt=0, Sel=0, Out=0, Out_valid=0, Busy=0. After release with Req=0 -> outputs stay 0.
- Single requester: Req=0100, D2=0xA5 -> Gnt=0100 and Sel=2 after edge 1; Out=0xA5 and Out_valid=1 after edge 2. Drop Req -> Gnt=0 after the next edge and Out_valid=0 one edge later.
- Zero-bubble handoff: Gnt=0001 with Req=1001. Drop Req[0] -> Gnt=1000 and Sel=3 after the same edge; Out switches from D0 to D3 with Out_valid continuously 1.
- Fairness (macro defined, MAX_HOLD=4): Req=1111 held from reset -> grants 0,1,2,3,0 in that order, each held 4 cycles, Busy constantly 1.
- Hold limit without contention (macro defined, MAX_HOLD=2): Req=0010 held 10 cycles -> Gnt=0010 for all 10 cycles.
- Macro undefined: Req=0011 held 20 cycles -> Gnt=0001 for all 20. Drop Req[0] -> Gnt=0010 after the next edge.
